// File: rtl/uart_pkg.sv
// Shared definitions for the UART command responder.
//   state_t       : responder FSM states
//   *_DEFAULT     : default sync / ack / nak byte values
//   CMD_WR/CMD_RD : command codes carried in the second frame byte
//   is_rx_state   : states in which received bytes are consumed
package uart_pkg;

    typedef enum logic [2:0] {
        S_SYNC,
        S_CMD,
        S_ADDR,
        S_DATA,
        S_EXEC,
        S_CAPT,
        S_RESP
    } state_t;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;
    localparam logic [7:0] ACK_DEFAULT  = 8'h5A;
    localparam logic [7:0] NAK_DEFAULT  = 8'hEE;
    localparam logic [7:0] CMD_WR       = 8'h01;
    localparam logic [7:0] CMD_RD       = 8'h02;

    function automatic logic is_rx_state(input state_t s);
        return (s == S_SYNC) || (s == S_CMD) || (s == S_ADDR) || (s == S_DATA);
    endfunction

endpackage

// File: rtl/uart_tx_sequencer.sv
// Reply byte sequencer: holds up to two reply bytes and hands them to the
// UART transmitter one at a time.
//   clk, rst_n      : clock, asynchronous active-low reset
//   load            : load a new reply (only issued while empty)
//   two             : reply is two bytes (byte0 then byte1), else byte0 only
//   byte0, byte1    : reply bytes
//   tx_busy         : UART transmitter busy
//   tx_data         : byte presented to the UART
//   tx_write_en     : 1-cycle launch pulse
//   empty           : no reply bytes left to launch
module uart_tx_sequencer (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic       two,
    input  logic [7:0] byte0,
    input  logic [7:0] byte1,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_write_en,
    output logic       empty
);

    logic [1:0] count_reg;
    logic [7:0] buf0_reg;
    logic [7:0] buf1_reg;
    logic [7:0] data_reg;
    logic       we_reg;
    logic       hold_reg;
    logic       launch;

    // The UART raises busy one cycle after it sees write_en, so busy is
    // ignored during the pulse cycle and the cycle after it (hold).
    assign launch = (count_reg != 2'd0) && !tx_busy && !we_reg && !hold_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 2'd0;
            buf0_reg  <= 8'h00;
            buf1_reg  <= 8'h00;
            data_reg  <= 8'h00;
            we_reg    <= 1'b0;
            hold_reg  <= 1'b0;
        end else begin
            we_reg   <= launch;
            hold_reg <= we_reg;
            if (load) begin
                count_reg <= two ? 2'd2 : 2'd1;
                buf0_reg  <= byte0;
                buf1_reg  <= byte1;
            end else if (launch) begin
                data_reg  <= buf0_reg;
                buf0_reg  <= buf1_reg;
                count_reg <= count_reg - 2'd1;
            end
        end
    end

    assign tx_data     = data_reg;
    assign tx_write_en = we_reg;
    assign empty       = (count_reg == 2'd0);

endmodule

// File: rtl/uart_cmd_responder.sv
// Byte-level command responder between the UART core and a register bus.
// Decodes SYNC,CMD,ADDR[,DATA] frames, performs register writes/reads and
// replies with ACK (+ read data) or NAK through the UART transmitter.
//   clk, rst_n             : clock, asynchronous active-low reset
//   rx_data, rx_valid      : received byte, sticky valid flag
//   rx_clear               : 1-cycle acknowledge of the received byte
//   tx_data, tx_write_en   : byte to send, 1-cycle launch pulse
//   tx_busy                : UART transmitter busy
//   reg_addr, reg_wdata    : register bus address / write data
//   reg_we, reg_re         : 1-cycle write / read strobes
//   reg_rdata              : read data, valid the cycle after reg_re
//   frame_err              : 1-cycle pulse on an inter-byte timeout
module uart_cmd_responder
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = SYNC_DEFAULT,
    parameter logic [7:0] ACK_BYTE       = ACK_DEFAULT,
    parameter logic [7:0] NAK_BYTE       = NAK_DEFAULT,
    parameter int         TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_clear,
    output logic [7:0] tx_data,
    output logic       tx_write_en,
    input  logic       tx_busy,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    output logic       reg_re,
    input  logic [7:0] reg_rdata,
    output logic       frame_err
);

    localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_reg, state_next;
    logic [7:0]       cmd_reg;
    logic [7:0]       addr_reg;
    logic [7:0]       wdata_reg;
    logic             rx_clear_reg;
    logic [1:0]       guard_cnt_reg;
    logic [CNT_W-1:0] to_cnt_reg;
    logic             frame_err_reg;

    logic             rx_guard;
    logic             accept;
    logic             counting;
    logic             timeout;
    logic             q_load;
    logic             q_two;
    logic [7:0]       q_byte0;
    logic             tx_empty;

    // The UART flag stays high for a while after rx_clear; the guard spans
    // the clear cycle plus two more so a sticky byte is taken only once.
    assign rx_guard = rx_clear_reg || (guard_cnt_reg != 2'd0);
    assign accept   = rx_valid && !rx_guard && is_rx_state(state_reg);
    assign counting = (state_reg == S_CMD) || (state_reg == S_ADDR) || (state_reg == S_DATA);
    // An accepted byte in the same cycle overrides the timeout.
    assign timeout  = counting && !accept && (to_cnt_reg == TO_LAST);

    always_comb begin
        state_next = state_reg;
        q_load     = 1'b0;
        q_two      = 1'b0;
        q_byte0    = ACK_BYTE;
        case (state_reg)
            S_SYNC: begin
                if (accept && rx_data == SYNC_BYTE) state_next = S_CMD;
            end
            S_CMD: begin
                if (accept)       state_next = S_ADDR;
                else if (timeout) state_next = S_SYNC;
            end
            S_ADDR: begin
                if (accept) begin
                    if (cmd_reg == CMD_WR)      state_next = S_DATA;
                    else if (cmd_reg == CMD_RD) state_next = S_EXEC;
                    else begin
                        q_load     = 1'b1;
                        q_byte0    = NAK_BYTE;
                        state_next = S_RESP;
                    end
                end else if (timeout) begin
                    state_next = S_SYNC;
                end
            end
            S_DATA: begin
                if (accept)       state_next = S_EXEC;
                else if (timeout) state_next = S_SYNC;
            end
            S_EXEC: begin
                if (cmd_reg == CMD_WR) begin
                    q_load     = 1'b1;
                    state_next = S_RESP;
                end else begin
                    state_next = S_CAPT;
                end
            end
            S_CAPT: begin
                // reg_rdata is valid now, one cycle after the read strobe.
                q_load     = 1'b1;
                q_two      = 1'b1;
                state_next = S_RESP;
            end
            S_RESP: begin
                if (tx_empty) state_next = S_SYNC;
            end
            default: state_next = S_SYNC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_SYNC;
            cmd_reg       <= 8'h00;
            addr_reg      <= 8'h00;
            wdata_reg     <= 8'h00;
            rx_clear_reg  <= 1'b0;
            guard_cnt_reg <= 2'd0;
            to_cnt_reg    <= '0;
            frame_err_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rx_clear_reg  <= accept;
            frame_err_reg <= timeout;
            if (rx_clear_reg)              guard_cnt_reg <= 2'd2;
            else if (guard_cnt_reg != 2'd0) guard_cnt_reg <= guard_cnt_reg - 2'd1;
            if (accept || !counting) to_cnt_reg <= '0;
            else                     to_cnt_reg <= to_cnt_reg + CNT_W'(1);
            if (accept && state_reg == S_CMD)  cmd_reg   <= rx_data;
            if (accept && state_reg == S_ADDR) addr_reg  <= rx_data;
            if (accept && state_reg == S_DATA) wdata_reg <= rx_data;
        end
    end

    uart_tx_sequencer u_tx_seq (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (q_load),
        .two         (q_two),
        .byte0       (q_byte0),
        .byte1       (reg_rdata),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .tx_write_en (tx_write_en),
        .empty       (tx_empty)
    );

    assign rx_clear  = rx_clear_reg;
    assign frame_err = frame_err_reg;
    assign reg_addr  = addr_reg;
    assign reg_wdata = wdata_reg;
    assign reg_we    = (state_reg == S_EXEC) && (cmd_reg == CMD_WR);
    assign reg_re    = (state_reg == S_EXEC) && (cmd_reg != CMD_WR);

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Bench for uart_cmd_responder: behavioural UART rx/tx byte models (tx busy
// rises two edges after write_en), a register-file model, a vector table,
// hand-written timeout/reset sequences and a randomized frame stream checked
// against a frame-level parser.
module tb_uart_cmd_responder;

    localparam int T = 64;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic       rx_clear;
    logic [7:0] tx_data;
    logic       tx_write_en;
    logic       tx_busy = 1'b0;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic       reg_re;
    logic [7:0] reg_rdata = 8'h00;
    logic       frame_err;

    uart_cmd_responder #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_clear(rx_clear), .tx_data(tx_data), .tx_write_en(tx_write_en),
        .tx_busy(tx_busy), .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- environment models (all act at negedge) ----------------
    int         cyc = 0;
    always @(posedge clk) cyc++;

    logic [7:0] rx_q[$];
    int         gap_q[$];
    int         cur_gap = 0;
    int         gap_cnt = 0;
    int         clear_cnt = 0;
    int         bad_clear = 0;
    int         last_clear_cyc = 0;

    always @(negedge clk) begin
        if (rx_clear) begin
            clear_cnt++;
            last_clear_cyc = cyc;
            if (!rx_valid) bad_clear++;
            rx_valid = 1'b0;
            gap_cnt  = cur_gap;
        end else if (!rx_valid) begin
            if (gap_cnt > 0) gap_cnt--;
            else if (rx_q.size() > 0) begin
                rx_data  = rx_q.pop_front();
                cur_gap  = gap_q.pop_front();
                rx_valid = 1'b1;
            end
        end
    end

    logic [7:0] tx_log[$];
    int         lag = 0;
    int         bcnt = 0;
    int         overlap_err = 0;

    always @(negedge clk) begin
        if (tx_write_en) begin
            if (tx_busy || lag > 0) overlap_err++;
            tx_log.push_back(tx_data);
            lag = 2;
        end else if (lag > 0) begin
            lag--;
            if (lag == 0) begin
                tx_busy = 1'b1;
                bcnt    = $urandom_range(3, 12);
            end
        end else if (tx_busy) begin
            bcnt--;
            if (bcnt == 0) tx_busy = 1'b0;
        end
    end

    logic [7:0] mem[256];
    int         we_cnt = 0;
    int         re_cnt = 0;
    int         ferr_cnt = 0;
    int         ferr_cyc = 0;
    logic [7:0] last_addr = 8'h00;
    logic [7:0] last_wdata = 8'h00;

    always @(negedge clk) begin
        if (reg_we) begin
            mem[reg_addr] = reg_wdata;
            we_cnt++;
            last_addr  = reg_addr;
            last_wdata = reg_wdata;
        end
        if (reg_re) begin
            reg_rdata = mem[reg_addr];
            re_cnt++;
            last_addr = reg_addr;
        end
        if (frame_err) begin
            ferr_cnt++;
            ferr_cyc = cyc;
        end
    end

    // ---------------- helpers ----------------
    task automatic push_byte(input logic [7:0] b, input int gap);
        rx_q.push_back(b);
        gap_q.push_back(gap);
    endtask

    task automatic clear_logs();
        tx_log.delete();
        we_cnt = 0; re_cnt = 0; clear_cnt = 0; ferr_cnt = 0;
    endtask

    task automatic wait_done(input int ntx, input int budget);
        int k = 0;
        while (!(tx_log.size() >= ntx && rx_q.size() == 0 && !rx_valid && !tx_busy && lag == 0)
               && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: budget %0d expired, got %0d tx bytes, expected %0d",
                     budget, tx_log.size(), ntx);
        end
        repeat (20) @(negedge clk);
    endtask

    typedef struct {
        int          nb;
        logic [63:0] bytes;
        logic [7:0]  pre;
        int          ntx;
        logic [7:0]  tx0;
        logic [7:0]  tx1;
        int          nwe;
        int          nre;
        logic [7:0]  addr;
        logic [7:0]  wdata;
    } vec_t;

    function automatic vec_t mk(int nb, logic [63:0] bytes, logic [7:0] pre, int ntx,
                                logic [7:0] tx0, logic [7:0] tx1, int nwe, int nre,
                                logic [7:0] addr, logic [7:0] wdata);
        vec_t v;
        v.nb = nb; v.bytes = bytes; v.pre = pre; v.ntx = ntx; v.tx0 = tx0; v.tx1 = tx1;
        v.nwe = nwe; v.nre = nre; v.addr = addr; v.wdata = wdata;
        return v;
    endfunction

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] stream[$];
        logic [7:0] exp_tx[$];
        logic [7:0] ref_mem[256];
        int         exp_we, exp_re, lat, k;

        vecs[0] = mk(4, 64'hA501103C_00000000, 8'h00, 1, 8'h5A, 8'h00, 1, 0, 8'h10, 8'h3C);
        vecs[1] = mk(3, 64'hA50210_0000000000, 8'h77, 2, 8'h5A, 8'h77, 0, 1, 8'h10, 8'h00);
        vecs[2] = mk(3, 64'hA50700_0000000000, 8'h00, 1, 8'hEE, 8'h00, 0, 0, 8'h00, 8'h00);
        vecs[3] = mk(4, 64'hA501FF00_00000000, 8'h55, 1, 8'h5A, 8'h00, 1, 0, 8'hFF, 8'h00);
        vecs[4] = mk(3, 64'hA502FF_0000000000, 8'h81, 2, 8'h5A, 8'h81, 0, 1, 8'hFF, 8'h00);
        vecs[5] = mk(3, 64'hA5A520_0000000000, 8'h00, 1, 8'hEE, 8'h00, 0, 0, 8'h20, 8'h00);
        vecs[6] = mk(3, 64'hA50000_0000000000, 8'h00, 1, 8'hEE, 8'h00, 0, 0, 8'h00, 8'h00);
        vecs[7] = mk(6, 64'h00FF13A50201_0000, 8'h4C, 2, 8'h5A, 8'h4C, 0, 1, 8'h01, 8'h00);

        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);

        // reset state
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("reset_outputs", {rx_clear, tx_data, tx_write_en, reg_addr, reg_wdata, reg_we, reg_re, frame_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // table-driven frames
        for (int i = 0; i < 8; i++) begin
            clear_logs();
            mem[vecs[i].addr] = vecs[i].pre;
            for (int b = 0; b < vecs[i].nb; b++)
                push_byte(vecs[i].bytes[63 - 8*b -: 8], $urandom_range(0, 6));
            wait_done(vecs[i].ntx, 2000);
            $display("vec %0d: %0d bytes in, %0d tx bytes, we=%0d re=%0d", i, vecs[i].nb, tx_log.size(), we_cnt, re_cnt);
            chk($sformatf("vec%0d_ntx", i), tx_log.size(), vecs[i].ntx);
            if (vecs[i].ntx >= 1 && tx_log.size() >= 1) chk($sformatf("vec%0d_tx0", i), tx_log[0], vecs[i].tx0);
            if (vecs[i].ntx >= 2 && tx_log.size() >= 2) chk($sformatf("vec%0d_tx1", i), tx_log[1], vecs[i].tx1);
            chk($sformatf("vec%0d_we", i), we_cnt, vecs[i].nwe);
            chk($sformatf("vec%0d_re", i), re_cnt, vecs[i].nre);
            if (vecs[i].nwe + vecs[i].nre > 0) chk($sformatf("vec%0d_addr", i), last_addr, vecs[i].addr);
            if (vecs[i].nwe > 0) chk($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].wdata);
            chk($sformatf("vec%0d_rx_clear", i), clear_cnt, vecs[i].nb);
            chk($sformatf("vec%0d_frame_err", i), ferr_cnt, 0);
        end

        // timeout after A5 01, then a normal read
        clear_logs();
        push_byte(8'hA5, 0);
        push_byte(8'h01, 0);
        k = 0;
        while (clear_cnt < 2 && k < 200) begin @(negedge clk); k++; end
        k = 0;
        while (ferr_cnt == 0 && k < 3*T) begin @(negedge clk); k++; end
        repeat (T) @(negedge clk);
        lat = ferr_cyc - last_clear_cyc;
        $display("timeout: frame_err count %0d, latency %0d cycles", ferr_cnt, lat);
        chk("timeout_pulses", ferr_cnt, 1);
        chk("timeout_latency_window", (lat >= T-2 && lat <= T+2), 1);
        chk("timeout_no_tx", tx_log.size(), 0);
        chk("timeout_no_strobe", we_cnt + re_cnt, 0);
        mem[8'h05] = 8'h5E;
        push_byte(8'hA5, 1); push_byte(8'h02, 1); push_byte(8'h05, 1);
        wait_done(2, 2000);
        $display("after timeout: %0d tx bytes", tx_log.size());
        chk("post_timeout_ntx", tx_log.size(), 2);
        if (tx_log.size() == 2) begin
            chk("post_timeout_tx0", tx_log[0], 8'h5A);
            chk("post_timeout_tx1", tx_log[1], 8'h5E);
        end
        chk("post_timeout_ferr", ferr_cnt, 1);

        // reset between the two reply bytes of a read
        clear_logs();
        mem[8'h30] = 8'h99;
        push_byte(8'hA5, 0); push_byte(8'h02, 0); push_byte(8'h30, 0);
        k = 0;
        while (!(tx_log.size() == 1 && tx_busy) && k < 500) begin @(negedge clk); k++; end
        chk("rst_first_byte_seen", tx_log.size(), 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", {rx_clear, tx_data, tx_write_en, reg_addr, reg_wdata, reg_we, reg_re, frame_err}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        $display("reset mid-reply: %0d tx bytes", tx_log.size());
        chk("rst_no_more_tx", tx_log.size(), 1);
        clear_logs();
        push_byte(8'hA5, 2); push_byte(8'h01, 2); push_byte(8'h44, 2); push_byte(8'h12, 2);
        wait_done(1, 2000);
        chk("rst_next_ntx", tx_log.size(), 1);
        if (tx_log.size() == 1) chk("rst_next_tx0", tx_log[0], 8'h5A);
        chk("rst_next_mem", mem[8'h44], 8'h12);

        // randomized frame stream vs frame-level reference parser
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom_range(0, 255));
            ref_mem[i] = mem[i];
        end
        clear_logs();
        for (int f = 0; f < 40; f++) begin
            int kind = $urandom_range(0, 9);
            int nj   = $urandom_range(0, 2);
            for (int j = 0; j < nj; j++) begin
                logic [7:0] jb = 8'($urandom_range(0, 255));
                if (jb == 8'hA5) jb = 8'h00;
                stream.push_back(jb);
            end
            stream.push_back(8'hA5);
            if (kind < 4) begin
                stream.push_back(8'h01);
                stream.push_back(8'($urandom_range(0, 15)));
                stream.push_back(8'($urandom_range(0, 255)));
            end else if (kind < 8) begin
                stream.push_back(8'h02);
                stream.push_back(8'($urandom_range(0, 15)));
            end else begin
                stream.push_back(8'($urandom_range(3, 255)));
                stream.push_back(8'($urandom_range(0, 255)));
            end
        end
        exp_we = 0; exp_re = 0;
        for (int i = 0; i < stream.size(); ) begin
            if (stream[i] != 8'hA5) begin
                i++;
            end else if (stream[i+1] == 8'h01) begin
                ref_mem[stream[i+2]] = stream[i+3];
                exp_tx.push_back(8'h5A);
                exp_we++;
                i += 4;
            end else if (stream[i+1] == 8'h02) begin
                exp_tx.push_back(8'h5A);
                exp_tx.push_back(ref_mem[stream[i+2]]);
                exp_re++;
                i += 3;
            end else begin
                exp_tx.push_back(8'hEE);
                i += 3;
            end
        end
        foreach (stream[i]) push_byte(stream[i], $urandom_range(0, 20));
        wait_done(exp_tx.size(), 40000);
        $display("random: %0d bytes in, %0d tx bytes (expected %0d)", stream.size(), tx_log.size(), exp_tx.size());
        chk("rand_ntx", tx_log.size(), exp_tx.size());
        for (int i = 0; i < exp_tx.size() && i < tx_log.size(); i++)
            chk($sformatf("rand_tx%0d", i), tx_log[i], exp_tx[i]);
        chk("rand_we", we_cnt, exp_we);
        chk("rand_re", re_cnt, exp_re);
        chk("rand_rx_clear", clear_cnt, stream.size());
        chk("rand_frame_err", ferr_cnt, 0);
        for (int a = 0; a < 16; a++) chk($sformatf("rand_mem%0d", a), mem[a], ref_mem[a]);

        chk("tx_overlap", overlap_err, 0);
        chk("rx_double_clear", bad_clear, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
